fir_mc_sequencer: RTL

// Parametrised control sequencer for the multi-channel FIR datapath. It sits between the host

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_idx_counter.sv | 23 ++
 rtl/fir_mc_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the multi-channel FIR sequencer and host register block.
package fir_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      SHIFT = 3'd2,
      MAC   = 3'd3,
      LATCH = 3'd4,
      WRITE = 3'd5,
      DONE  = 3'd6
   } seq_state_t;

   // A run configuration is usable only if every dimension is non-empty and within the datapath size.
   function automatic logic cfg_legal(input int unsigned n_taps,
                                      input int unsigned n_ch,
                                      input int unsigned n_samples,
                                      input int unsigned taps_max,
                                      input int unsigned ch_max);
      return (n_taps >= 32'd1) && (n_taps <= taps_max) &&
             (n_ch >= 32'd1) && (n_ch <= ch_max) &&
             (n_samples >= 32'd1);
   endfunction

endpackage

// File: rtl/fir_idx_counter.sv
// Saturating index counter: counts up to last_val and holds there until cleared.
module fir_idx_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last_val,
   output logic [W-1:0] cnt,
   output logic         is_last
);

   assign is_last = (cnt == last_val);

   // Clear wins over increment; the count never moves past last_val.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (clr)              cnt <= '0;
      else if (en && !is_last)   cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/fir_mc_sequencer.sv
// Control sequencer for the multi-channel FIR datapath: walks taps, channels and samples.
module fir_mc_sequencer
   import fir_pkg::*;
#(
   parameter  int unsigned N_TAPS_MAX = 64,
   parameter  int unsigned N_CH       = 4,
   parameter  int unsigned SAMP_W     = 16,
   localparam int unsigned TAP_W      = $clog2(N_TAPS_MAX),
   localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [TAP_W:0]    cfg_n_taps,
   input  logic [CH_W:0]     cfg_n_ch,
   input  logic [SAMP_W-1:0] cfg_n_samples,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              err_cfg,
   output logic              dp_sel,
   output logic              coef_load,
   output logic              shift_en,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              acc_latch,
   output logic [TAP_W-1:0]  tap_idx,
   output logic [CH_W-1:0]   ch_idx,
   output logic [SAMP_W-1:0] samp_idx,
   output logic              out_valid,
   input  logic              out_ready
);

   seq_state_t        state, nxt;
   logic [TAP_W-1:0]  tap_last_q;
   logic [CH_W-1:0]   ch_last_q;
   logic [SAMP_W-1:0] samp_last_q;
   logic              cfg_ok, start_ok, abort_ok, hs;
   logic              tap_last, ch_last, samp_last;
   logic              acc_clr_q;
   logic              busy_d, done_d, aborted_d, err_cfg_d, coef_load_d;
   logic              shift_en_d, acc_clr_d, acc_en_d, acc_latch_d, out_valid_d;

   assign cfg_ok   = cfg_legal(32'(cfg_n_taps), 32'(cfg_n_ch), 32'(cfg_n_samples),
                               N_TAPS_MAX, N_CH);
   assign start_ok = (state == IDLE) && start && cfg_ok;
   assign abort_ok = (state != IDLE) && abort;
   assign hs       = (state == WRITE) && out_ready && !abort;

   // The handshake clear must land in the same cycle as out_ready, so it bypasses the output flop.
   assign acc_clr  = acc_clr_q | hs;

   // Configuration is frozen for the whole run at the moment start is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_last_q  <= '0;
         ch_last_q   <= '0;
         samp_last_q <= '0;
      end else if (start_ok) begin
         tap_last_q  <= TAP_W'(cfg_n_taps - (TAP_W+1)'(1));
         ch_last_q   <= CH_W'(cfg_n_ch - (CH_W+1)'(1));
         samp_last_q <= cfg_n_samples - SAMP_W'(1);
      end
   end

   fir_idx_counter #(.W(TAP_W)) u_tap_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (start_ok || abort_ok || (nxt == SHIFT)),
      .en       (state == MAC),
      .last_val (tap_last_q),
      .cnt      (tap_idx),
      .is_last  (tap_last)
   );

   fir_idx_counter #(.W(CH_W)) u_ch_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (start_ok || abort_ok || (state == INIT) || (hs && ch_last)),
      .en       (hs && !ch_last),
      .last_val (ch_last_q),
      .cnt      (ch_idx),
      .is_last  (ch_last)
   );

   fir_idx_counter #(.W(SAMP_W)) u_samp_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (start_ok || abort_ok || (state == INIT)),
      .en       (hs && ch_last),
      .last_val (samp_last_q),
      .cnt      (samp_idx),
      .is_last  (samp_last)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start && cfg_ok) nxt = INIT;
         INIT:    nxt = SHIFT;
         SHIFT:   nxt = MAC;
         MAC:     if (tap_last) nxt = LATCH;
         LATCH:   nxt = WRITE;
         WRITE:   if (out_ready) nxt = (ch_last && samp_last) ? DONE : SHIFT;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (abort_ok) nxt = IDLE;
   end

   // Output decode from the upcoming state so the registered strobes line up with it.
   always_comb begin
      busy_d      = (nxt != IDLE);
      done_d      = (nxt == DONE);
      aborted_d   = abort_ok;
      err_cfg_d   = (state == IDLE) && start && !cfg_ok;
      coef_load_d = (nxt == INIT);
      shift_en_d  = (nxt == SHIFT);
      acc_clr_d   = (nxt == INIT);
      acc_en_d    = (nxt == MAC);
      acc_latch_d = (nxt == LATCH);
      out_valid_d = (nxt == WRITE);
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         err_cfg   <= 1'b0;
         dp_sel    <= 1'b0;
         coef_load <= 1'b0;
         shift_en  <= 1'b0;
         acc_clr_q <= 1'b0;
         acc_en    <= 1'b0;
         acc_latch <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         busy      <= busy_d;
         done      <= done_d;
         aborted   <= aborted_d;
         err_cfg   <= err_cfg_d;
         dp_sel    <= busy_d;
         coef_load <= coef_load_d;
         shift_en  <= shift_en_d;
         acc_clr_q <= acc_clr_d;
         acc_en    <= acc_en_d;
         acc_latch <= acc_latch_d;
         out_valid <= out_valid_d;
      end
   end

endmodule
